// File: rtl/ysyx_23060203_mdu_pkg.sv
// ysyx_23060203_mdu_pkg: shared op/state types and operand-sign helpers for the MDU
package ysyx_23060203_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic is_signed_b(mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/ysyx_23060203_mdu_if.sv
// ysyx_23060203_mdu_if: request/result handshake bundle between the EXU and the MDU
interface ysyx_23060203_mdu_if
    import ysyx_23060203_mdu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    mdu_op_e         in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_data;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ysyx_23060203_mdu_negate.sv
// ysyx_23060203_mdu_negate: conditional two's-complement negate
module ysyx_23060203_mdu_negate #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic            en_i,
    output logic [XLEN-1:0] y_o
);
    assign y_o = en_i ? -a_i : a_i;
endmodule

// File: rtl/ysyx_23060203_mdu.sv
// ysyx_23060203_mdu: iterative RV32M multiply/divide unit; MDU_EARLY_OUT_EN enables multiply early-out
module ysyx_23060203_mdu
    import ysyx_23060203_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input logic                 clock,
    input logic                 reset,
    input logic                 flush,
    ysyx_23060203_mdu_if.slave  io
);
    localparam int CW      = $clog2(XLEN) + 1;
    localparam int MUL_CYC = XLEN / MUL_STEP;

    mdu_state_e          state_q, state_d;
    mdu_op_e             op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d, res_q, res_d;
    logic                neg_q, neg_d, rneg_q, rneg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   partial, mul_acc, div_acc, prod_fix;
    logic [XLEN-1:0]     a_mag, b_mag, quo_fix, rem_fix;
    logic [XLEN:0]       rem_sh, trial;
    logic                sa, sb, accept, b_zero, ovf, mul_last;

    assign io.in_ready  = (state_q == IDLE) & ~flush;
    assign io.out_valid = state_q == DONE;
    assign io.out_data  = res_q;

    assign accept = io.in_valid & io.in_ready;
    assign sa     = is_signed_a(io.in_op) & io.in_a[XLEN-1];
    assign sb     = is_signed_b(io.in_op) & io.in_b[XLEN-1];
    assign b_zero = io.in_b == '0;
    assign ovf    = is_signed_b(io.in_op) & is_div(io.in_op)
                  & (io.in_a == {1'b1, {(XLEN-1){1'b0}}}) & (io.in_b == '1);

    // restoring-division step: shift one dividend bit in, subtract divisor if it fits
    assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    assign trial   = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
    assign div_acc = {trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0], acc_q[XLEN-2:0], ~trial[XLEN]};
    assign mul_acc = acc_q + partial;

`ifdef MDU_EARLY_OUT_EN
    assign mul_last = (cnt_q == CW'(1)) | ((mplier_q >> MUL_STEP) == '0);
`else
    assign mul_last = cnt_q == CW'(1);
`endif

    ysyx_23060203_mdu_negate #(.XLEN(XLEN)) u_neg_a (.a_i(io.in_a), .en_i(sa), .y_o(a_mag));
    ysyx_23060203_mdu_negate #(.XLEN(XLEN)) u_neg_b (.a_i(io.in_b), .en_i(sb), .y_o(b_mag));
    ysyx_23060203_mdu_negate #(.XLEN(2*XLEN)) u_neg_p (.a_i(mul_acc), .en_i(neg_q), .y_o(prod_fix));
    ysyx_23060203_mdu_negate #(.XLEN(XLEN)) u_neg_q (.a_i(div_acc[XLEN-1:0]), .en_i(neg_q), .y_o(quo_fix));
    ysyx_23060203_mdu_negate #(.XLEN(XLEN)) u_neg_r (.a_i(div_acc[2*XLEN-1:XLEN]), .en_i(rneg_q), .y_o(rem_fix));

    // radix-2^MUL_STEP partial product of the low multiplier digit
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++)
            partial = partial + (mplier_q[j] ? (mcand_q << j) : '0);
    end

    // next-state and datapath update; flush overrides everything
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_d    = res_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d     = io.in_op;
                neg_d    = sa ^ sb;
                rneg_d   = sa;
                acc_d    = is_div(io.in_op) ? {{XLEN{1'b0}}, a_mag} : '0;
                mcand_d  = {{XLEN{1'b0}}, is_div(io.in_op) ? b_mag : a_mag};
                mplier_d = b_mag;
                cnt_d    = is_div(io.in_op) ? CW'(XLEN) : CW'(MUL_CYC);
                state_d  = is_div(io.in_op) ? DIV : MUL;
                if (is_div(io.in_op) && b_zero) begin
                    state_d = DONE;
                    res_d   = io.in_op[1] ? io.in_a : '1;
                end else if (ovf) begin
                    state_d = DONE;
                    res_d   = io.in_op[1] ? '0 : io.in_a;
                end
`ifdef MDU_EARLY_OUT_EN
                else if (b_zero) begin
                    state_d = DONE;
                    res_d   = '0;
                end
`endif
            end
            MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q - CW'(1);
                if (mul_last) begin
                    state_d = DONE;
                    res_d   = op_q == MDU_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end
            end
            DIV: begin
                acc_d = div_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = op_q[1] ? rem_fix : quo_fix;
                end
            end
            DONE: state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060203_mdu.sv
// tb_ysyx_23060203_mdu: directed-vector bench for the MDU
module tb_ysyx_23060203_mdu;
    import ysyx_23060203_mdu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ysyx_23060203_mdu_if #(.XLEN(32)) io ();

    ysyx_23060203_mdu #(.XLEN(32), .MUL_STEP(2)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .io    (io)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mul_lat(input logic [31:0] bm);
`ifdef MDU_EARLY_OUT_EN
        int n = 0;
        if (bm == 0) return 1;
        while (bm != 0) begin
            bm = bm >> 2;
            n++;
        end
        return n + 1;
`else
        return 17;
`endif
    endfunction

    task automatic run(input string tag, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold);
        int k;
        logic busy_bad, stable;
        logic [31:0] d0;
        @(negedge clock);
        chk({tag, "_rdy"}, 64'(io.in_ready), 64'(1));
        io.out_ready = (hold == 0);
        io.in_valid  = 1'b1;
        io.in_op     = op;
        io.in_a      = a;
        io.in_b      = b;
        @(posedge clock);
        #1;
        io.in_valid = 1'b0;
        k = 1;
        busy_bad = 1'b0;
        while (!io.out_valid && k < 100) begin
            if (io.in_ready) busy_bad = 1'b1;
            @(posedge clock);
            #1;
            k++;
        end
        if (io.in_ready) busy_bad = 1'b1;
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_data"}, 64'(io.out_data), 64'(exp));
        chk({tag, "_busy"}, 64'(busy_bad), 64'(0));
        if (hold > 0) begin
            d0 = io.out_data;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clock);
                #1;
                if (!io.out_valid || io.out_data !== d0) stable = 1'b0;
            end
            chk({tag, "_hold"}, 64'(stable), 64'(1));
            io.out_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        chk({tag, "_idle"}, 64'(io.in_ready), 64'(1));
        chk({tag, "_vld0"}, 64'(io.out_valid), 64'(0));
    endtask

    initial begin
        int k;
        logic seen;
        io.in_valid  = 1'b0;
        io.in_op     = MDU_MUL;
        io.in_a      = '0;
        io.in_b      = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(io.out_valid), 64'(0));
        chk("rst_data", 64'(io.out_data), 64'(0));
        chk("rst_ready", 64'(io.in_ready), 64'(1));

        run("mul",    MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, mul_lat(32'd3), 0);
        run("mulhu",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, mul_lat(32'hFFFFFFFF), 0);
        run("mulh",   MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, mul_lat(32'd1), 0);
        run("mulhsu", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, mul_lat(32'hFFFFFFFF), 0);
        run("mulh2",  MDU_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, mul_lat(32'd2), 0);
        run("div",    MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
        run("rem",    MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
        run("divu",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       33, 5);
        run("remu",   MDU_REMU,   32'd100,      32'd7,        32'd2,        33, 0);
        run("divu0",  MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
        run("rem0",   MDU_REM,    32'd5,        32'd0,        32'd5,        1, 0);
        run("divov",  MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run("remov",  MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 3);

        @(negedge clock);
        io.in_valid = 1'b1;
        io.in_op    = MDU_DIV;
        io.in_a     = 32'd1000;
        io.in_b     = 32'd3;
        @(posedge clock);
        #1;
        io.in_valid = 1'b0;
        seen = io.out_valid;
        repeat (9) begin
            @(posedge clock);
            #1;
            seen = seen | io.out_valid;
        end
        flush       = 1'b1;
        io.in_valid = 1'b1;
        io.in_op    = MDU_MUL;
        io.in_a     = 32'd9;
        io.in_b     = 32'd9;
        #1;
        chk("flush_rdy0", 64'(io.in_ready), 64'(0));
        @(posedge clock);
        #1;
        flush       = 1'b0;
        io.in_valid = 1'b0;
        #1;
        chk("flush_rdy1", 64'(io.in_ready), 64'(1));
        k = 0;
        while (k < 40) begin
            seen = seen | io.out_valid;
            @(posedge clock);
            #1;
            k++;
        end
        chk("flush_novld", 64'(seen), 64'(0));
        run("mul_aft", MDU_MUL, 32'd6, 32'd7, 32'd42, mul_lat(32'd7), 0);

        run("mul31", MDU_MUL, 32'd3, 32'd1, 32'd3, mul_lat(32'd1), 0);
        run("mul0",  MDU_MUL, 32'd5, 32'd0, 32'd0, mul_lat(32'd0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_23060203_mdu.md
Name: ysyx_23060203_mdu

Overview:
- Iterative RV32M multiply/divide functional unit for the EXU.
- Parametrised in operand width and multiply bits-per-cycle; adds flush and RISC-V corner-case handling.
- Sits beside the LSU inside the EXU, driven with the same valid/ready handshake.
- Accepts an operation only when idle and holds its result until consumed.

Parameters:
- XLEN, 32, operand and result width.
- MUL_STEP, 2, multiplier bits retired per cycle. Must divide XLEN; legal values are 1, 2 and 4.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  abort any in-flight operation (pipeline flush).
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  funct3 encoding:
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu
  - 100 div, 101 divu, 110 rem, 111 remu
- in_a  in  XLEN  rs1 value.
- in_b  in  XLEN  rs2 value.
- out_ready  in  1  consumer accepts result.
- out_valid  out  1  result available.
- out_data  out  XLEN  result.

Behaviour:
- Reset:
  - State goes to IDLE.
  - out_valid=0, out_data=0, in_ready=1 from the cycle after reset deasserts.
  - Reset mid-operation discards the operation.
- FSM has four states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) & ~flush.
- Acceptance: on in_valid&in_ready at cycle T, the unit latches op, operand magnitudes and result-sign flags.
- Sign handling:
  - mul, mulh: both operands signed.
  - mulhsu: a signed, b unsigned.
  - mulhu, divu, remu: both operands unsigned.
  - div, rem: both operands signed.
  - The core loop always works on magnitudes. The final result is conditionally two's-complement negated.
- Multiply:
  - IDLE→MUL, then radix-2^MUL_STEP shift-add over a 2*XLEN accumulator for XLEN/MUL_STEP cycles, then →DONE.
  - out_valid rises at T+1+XLEN/MUL_STEP (T+17 at defaults).
  - The full 2*XLEN product is negated when the operand signs differ (signed operands only).
  - mul returns the low XLEN bits; all mulh* variants return the high XLEN bits.
- Divide:
  - IDLE→DIV, restoring division 1 bit/cycle for XLEN cycles, then →DONE.
  - out_valid rises at T+1+XLEN (T+33).
  - Quotient is negated when signs differ (div only). Remainder takes the dividend's sign (rem only).
- Divide special cases (IDLE→DONE directly, out_valid at T+1):
  - b==0: quotient = all ones, remainder = a (signed and unsigned).
  - Signed overflow, i.e. a==-2^(XLEN-1) and b==-1 (div/rem only): quotient = a, remainder = 0.
- DONE:
  - out_valid=1 and out_data stays stable until out_ready.
  - On out_valid&out_ready the unit returns →IDLE next cycle.
  - No back-to-back acceptance in the handshake cycle: in_ready is 0 while in DONE.
- Flush:
  - Any state → IDLE next cycle; out_valid=0 next cycle.
  - A request presented in the flush cycle is not accepted.
  - Flush wins over a simultaneous out_ready handshake; the result counts as discarded.
- out_data holds its last value outside DONE; only DONE gives it meaning.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in MUL, if the remaining unprocessed multiplier magnitude bits are all zero, the unit goes →DONE at the next cycle edge. This also covers b==0 at acceptance, with out_valid at T+1. Results are bit-identical to the non-early path.
- Undefined: multiply latency is always fixed at XLEN/MUL_STEP+1. Division is unaffected either way.

Decomposition:
- Shared package ysyx_23060203_mdu_pkg holds:
  - mdu_op_e enum for the funct3 codes.
  - mdu_state_e enum {IDLE, MUL, DIV, DONE}.
  - Helpers is_div(op) and is_signed_a/b(op).
- One sub-module, ysyx_23060203_mdu_negate: XLEN-parametrised conditional two's-complement negate. It is instantiated for operand magnitudes and result sign fix-up.

Test Plan:
- mul a=7, b=-3 with out_ready=1 → out_valid at T+17, out_data=0xFFFFFFEB; in_ready=0 during T+1..T+17.
- mulhu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE; mulh with the same operands → 0x00000000; mulhsu a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- div a=-7, b=2 → out_data=0xFFFFFFFD at T+33; rem with the same operands → 0xFFFFFFFF; divu a=100, b=7 → 14; remu → 2.
- Corner cases:
  - divu a=5, b=0 → 0xFFFFFFFF at T+1.
  - rem a=5, b=0 → 5.
  - div a=0x80000000, b=0xFFFFFFFF → 0x80000000 at T+1.
  - rem with the same operands → 0.
- Hold and flush:
  - out_ready=0 for 5 cycles after DONE → out_valid and out_data stable.
  - Flush at T+10 of a div → out_valid never rises; in_ready=1 at T+11; the next mul completes correctly.
- MDU_EARLY_OUT_EN defined:
  - mul a=3, b=1 → out_valid at T+2, result 3.
  - mul b=0 → T+1, result 0.
  - With the macro undefined, both of these take T+17.
